packet_receiver: RTL
====================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 8'h7E, per-lane start-of-frame marker.
REQ-002 SHALL have parameter LANE_BITS, default 218, payload bits per lane after the marker.
REQ-003 SHALL have parameter SKEW_MAX, default 16, maximum clk cycles between the first and last lane completing.
REQ-004 clk  input  1  receive clock; all state on posedge.
REQ-005 rst_l  input  1  asynchronous, active-low reset.
REQ-006 game_active  input  1  receive enable; low aborts and idles all lanes.
REQ-007 serial_in_0..serial_in_3  input  1 each  data lanes; lane 0 carries packet bits [835:627], lane 3 bits [208:0].
REQ-008 pkt_valid  output  1  one-cycle pulse: new, non-duplicate packet on pkt_data.
REQ-009 pkt_data  output  836  last accepted packet: seqNum[835:832], garbage[831:828], hold[827:824], piece_queue[823:800], playfield[799:0].
REQ-010 send_ack  output  1  one-cycle pulse requesting an ACK for ack_seqNum.
REQ-011 ack_seqNum  output  1  sequence bit of the most recent well-formed packet.
REQ-012 frame_error  output  1  one-cycle pulse: packet discarded (skew timeout or check failure).

Function
REQ-013 Each serial input SHALL pass through a 2-flop synchronizer; "sample" below means the synchronized value.
REQ-014 Each lane SHALL run its own FSM: HUNT -> RECV when the last 8 samples, oldest first, equal SYNC_PATTERN; RECV -> DONE after exactly LANE_BITS further samples; DONE holds until released by REQ-016/017.
REQ-015 Lane payload SHALL be shifted in MSB first; the top 9 bits are padding, the low 209 bits are that lane's packet slice.
REQ-016 Collector FSM states IDLE, COLLECT, CHECK: IDLE -> COLLECT when any lane reaches DONE; COLLECT -> CHECK when all four lanes are DONE; CHECK -> IDLE unconditionally, releasing all lanes to HUNT.
REQ-017 In COLLECT an 8-bit skew counter SHALL increment each cycle; at SKEW_MAX with lanes not all DONE the FSM SHALL return to IDLE, release all lanes to HUNT, and pulse frame_error.
REQ-018 In CHECK a packet SHALL be well-formed iff all 36 padding bits are 0 and the 4 seqNum bits are all equal; otherwise pulse frame_error and change no other output.
REQ-019 For a well-formed packet: send_ack SHALL pulse and ack_seqNum SHALL take seqNum[0], regardless of duplication.
REQ-020 A well-formed packet SHALL be a duplicate iff a packet has been accepted since reset and its seqNum equals the last accepted one; duplicates do not update pkt_data and do not pulse pkt_valid.
REQ-021 A non-duplicate well-formed packet SHALL load pkt_data and pulse pkt_valid on the same cycle as send_ack.
REQ-022 Latency: pkt_valid/send_ack/frame_error SHALL be high exactly 2 cycles after the edge on which the final payload bit of the last lane is sampled.
REQ-023 pkt_data SHALL be stable between pkt_valid pulses.
REQ-024 game_active low SHALL, on the next edge, force all lanes to HUNT and the collector to IDLE without pulsing any output; pkt_data, ack_seqNum and the duplicate history are kept.
REQ-025 A SYNC_PATTERN appearing inside a RECV payload SHALL be treated as data.
REQ-026 A lane in DONE SHALL ignore its input until released.

Reset
REQ-027 On rst_l low, all pulses, pkt_data, ack_seqNum, the skew counter, synchronizers and the "accepted since reset" flag SHALL clear; lanes enter HUNT and the collector enters IDLE.
REQ-028 A reset mid-frame SHALL discard partial data with no output pulse after release.

Verification
REQ-029 Aligned frames, seq 0, garbage 4'h3, playfield all-ones -> one pkt_valid and one send_ack, ack_seqNum 0, pkt_data[831:828] = 4'h3.
REQ-030 Same frame sent twice -> second gives send_ack only, no pkt_valid; next frame with seq 1 -> pkt_valid, ack_seqNum 1.
REQ-031 Lane 3 delayed 10 cycles -> accepted; lane 3 delayed 20 cycles -> frame_error at cycle SKEW_MAX after first DONE, no send_ack.
REQ-032 seqNum field 4'b0100 or any padding bit set -> frame_error, pkt_data unchanged.
REQ-033 game_active dropped mid-RECV, then a full frame -> no pulse for the aborted frame, normal accept of the next.
REQ-034 Payload containing 8'h7E plus rst_l pulsed mid-frame -> marker treated as data before reset; no output after reset until a fresh frame is received.

Source files
------------

// File: rtl/packet_receiver.sv
// packet_receiver: four-lane serial frame receiver with per-lane sync hunt, lane deskew,
// integrity check and duplicate-sequence filtering.
module packet_receiver #(
    parameter logic [7:0] SYNC_PATTERN = 8'h7E,
    parameter int         LANE_BITS    = 218,
    parameter int         SKEW_MAX     = 16
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         game_active,
    input  logic         serial_in_0,
    input  logic         serial_in_1,
    input  logic         serial_in_2,
    input  logic         serial_in_3,
    output logic         pkt_valid,
    output logic [835:0] pkt_data,
    output logic         send_ack,
    output logic         ack_seqNum,
    output logic         frame_error
);
    localparam int SLICE = 209;
    localparam int CW    = $clog2(LANE_BITS + 1);

    typedef enum logic [1:0] {HUNT, RECV, DONE} lane_state_t;
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} coll_state_t;

    logic [3:0]           sync_a, sync_b;
    lane_state_t          lane_st [4];
    logic [6:0]           hist    [4];
    logic [CW-1:0]        bit_cnt [4];
    logic [LANE_BITS-1:0] shreg   [4];
    logic [3:0]           lane_done;
    coll_state_t          coll_st;
    logic [7:0]           skew_cnt;
    logic                 accepted;
    logic                 timeout, release_lanes, pad_ok, seq_ok, dup;
    logic [835:0]         packet;

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {serial_in_3, serial_in_2, serial_in_1, serial_in_0};
            sync_b <= sync_a;
        end

    always_comb begin
        lane_done = '0;
        for (int i = 0; i < 4; i++) lane_done[i] = lane_st[i] == DONE;
        packet = {shreg[0][SLICE-1:0], shreg[1][SLICE-1:0], shreg[2][SLICE-1:0], shreg[3][SLICE-1:0]};
        pad_ok = shreg[0][LANE_BITS-1:SLICE] == '0 && shreg[1][LANE_BITS-1:SLICE] == '0 &&
                 shreg[2][LANE_BITS-1:SLICE] == '0 && shreg[3][LANE_BITS-1:SLICE] == '0;
        seq_ok = packet[835:832] == 4'h0 || packet[835:832] == 4'hF;
        dup = accepted && packet[835:832] == pkt_data[835:832];
        timeout = coll_st == COLLECT && !(&lane_done) && skew_cnt == 8'(SKEW_MAX);
        release_lanes = coll_st == CHECK || timeout;
    end

    // History is cleared on release so stale payload bits can never complete a marker.
    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            for (int i = 0; i < 4; i++) begin
                lane_st[i] <= HUNT;
                hist[i]    <= '0;
                bit_cnt[i] <= '0;
                shreg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!game_active || release_lanes) begin
                    lane_st[i] <= HUNT;
                    hist[i]    <= '0;
                end else begin
                    hist[i] <= {hist[i][5:0], sync_b[i]};
                    case (lane_st[i])
                        HUNT:
                            if ({hist[i], sync_b[i]} == SYNC_PATTERN) begin
                                lane_st[i] <= RECV;
                                bit_cnt[i] <= '0;
                            end
                        RECV: begin
                            shreg[i]   <= {shreg[i][LANE_BITS-2:0], sync_b[i]};
                            bit_cnt[i] <= bit_cnt[i] + CW'(1);
                            if (bit_cnt[i] == CW'(LANE_BITS - 1)) lane_st[i] <= DONE;
                        end
                        default: ;
                    endcase
                end
            end
        end

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            coll_st     <= IDLE;
            skew_cnt    <= '0;
            accepted    <= 1'b0;
            pkt_data    <= '0;
            ack_seqNum  <= 1'b0;
            pkt_valid   <= 1'b0;
            send_ack    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            pkt_valid   <= 1'b0;
            send_ack    <= 1'b0;
            frame_error <= 1'b0;
            if (!game_active) begin
                coll_st  <= IDLE;
                skew_cnt <= '0;
            end else begin
                case (coll_st)
                    IDLE: begin
                        skew_cnt <= (|lane_done) ? 8'd1 : 8'd0;
                        coll_st  <= (&lane_done) ? CHECK : (|lane_done) ? COLLECT : IDLE;
                    end
                    COLLECT:
                        if (&lane_done) coll_st <= CHECK;
                        else if (timeout) begin
                            coll_st     <= IDLE;
                            skew_cnt    <= '0;
                            frame_error <= 1'b1;
                        end else skew_cnt <= skew_cnt + 8'd1;
                    CHECK: begin
                        coll_st  <= IDLE;
                        skew_cnt <= '0;
                        if (pad_ok && seq_ok) begin
                            send_ack   <= 1'b1;
                            ack_seqNum <= packet[832];
                            if (!dup) begin
                                pkt_valid <= 1'b1;
                                pkt_data  <= packet;
                                accepted  <= 1'b1;
                            end
                        end else frame_error <= 1'b1;
                    end
                    default: coll_st <= IDLE;
                endcase
            end
        end
endmodule
